sd_read_sector: RTL
===================

Name: sd_read_sector

Overview:
Downstream consumer of the SD SPI initialisation stage.
- Once `init_ok` is high, it accepts single-sector read requests.
- For each request it issues CMD17 on the SPI lines, waits for the R1 response and the 0xFE start token, then streams 512 data bytes out byte-by-byte. The 16-bit CRC that follows is consumed.
- The top level muxes `SD_MOSI`/`SD_CSn` between the init stage (while `init_ok`=0) and this block (while `init_ok`=1).

Parameters:
- R1_TIMEOUT, 255, max SD_CK cycles after CMD17 without a response start bit before error.
- TOKEN_TIMEOUT, 4095, max SD_CK cycles after R1 without a 0xFE token before error.
- GAP_CLKS, 8, dummy clocks with CS high after each transfer (success or error).

Ports:
- SD_CK  input  1  single SPI clock; TX registers on falling edge, RX sampling on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- init_ok  input  1  card initialised; requests are ignored while low.
- rd_req  input  1  one-cycle read request pulse.
- rd_addr  input  32  sector (block) address, SDHC block addressing.
- SD_MISO  input  1  card data out.
- SD_MOSI  output  1  card data in.
- SD_CSn  output  1  card chip select, active low.
- rd_busy  output  1  high from request acceptance until the gap completes.
- rd_data  output  8  received byte, valid with `rd_valid`.
- rd_valid  output  1  one-cycle strobe per data byte.
- rd_done  output  1  one-cycle pulse at end of a successful transfer.
- rd_err  output  1  one-cycle pulse at end of a failed transfer.
- rd_err_code  output  2  01 = R1 timeout/nonzero, 10 = token timeout, 11 = CRC mismatch; held until next request.

Behaviour:
- Reset values:
  - `SD_MOSI`=1, `SD_CSn`=1, `rd_busy`=0, `rd_data`=0, `rd_valid`=0, `rd_done`=0, `rd_err`=0, `rd_err_code`=0.
  - State=IDLE.
  - Reset mid-operation aborts immediately to these values; no gap clocks are sent.
- IDLE:
  - `rd_req` is accepted only when `init_ok`=1 and `rd_busy`=0.
  - On acceptance, `rd_addr` is latched and `rd_busy` rises on the next edge.
  - `rd_req` while busy, or while `init_ok`=0, is dropped silently.
- SEND_CMD:
  - CS low; shift 48 bits MSB first: 0x51, addr[31:24..7:0], 0xFF.
  - One bit per SD_CK; MOSI held 1 afterwards.
- WAIT_R1:
  - First 0 bit on MISO starts an 8-bit capture.
  - R1==0x00 → WAIT_TOKEN.
  - R1≠0x00, or no start bit within R1_TIMEOUT → error code 01.
- WAIT_TOKEN:
  - Bit-wise hunt: an 8-bit shift window equal to 0xFE means token found; byte alignment is taken from the token end.
  - No token within TOKEN_TIMEOUT → error code 10.
- RX_DATA:
  - 512 bytes; `rd_valid` pulses the cycle after each 8th bit, with `rd_data` stable that cycle.
  - 10-bit byte counter, 0..511; exits at 511. No wrap.
  - No backpressure: the consumer must accept one byte per 8 SD_CK.
- RX_CRC: 16 bits shifted in.
- GAP:
  - CS high, MOSI high for GAP_CLKS clocks.
  - Then pulse `rd_done` or `rd_err` and return to IDLE.
  - `rd_busy` falls in the same cycle as the pulse.
- `init_ok` falling mid-transfer: abort to GAP, error code 01.
- Latency:
  - `rd_req` to first MOSI bit: 2 SD_CK.
  - Last CRC bit to `rd_done`: GAP_CLKS+1.

Optional Feature:
- Macro `SD_RD_CRC16_EN`.
- Defined:
  - CRC16-CCITT (poly 0x1021, init 0) is computed over the 512 data bytes and compared with the received CRC.
  - Mismatch → `rd_err` with code 11 instead of `rd_done`. Data strobes are unaffected.
- Undefined: CRC bits are consumed and discarded; code 11 is never produced.

Decomposition:
- Shared package/include: command macros (`CMD17` framing, existing CMD0/8/55/ACMD41), the token constant 0xFE, error code constants, and state encodings.
- One sub-module: `sd_crc16` (serial bit-in CRC16, clear/enable inputs), instantiated only under `SD_RD_CRC16_EN`.

Test Plan:
1. Basic read:
   - Stimulus: `init_ok`=1, `rd_req` with `rd_addr`=0x00000010. Card model returns R1=0x00, 3 bytes of 0xFF, token 0xFE, data byte i = i%256, then the CRC.
   - Response: MOSI carries 51 00 00 00 10 FF; 512 `rd_valid` strobes with `rd_data` 00..FF repeating; `rd_done` after 8 gap clocks.
2. Bad R1:
   - Stimulus: card returns R1=0x05.
   - Response: no `rd_valid`; `rd_err` with code 01; `SD_CSn` high.
3. Token timeout:
   - Stimulus: card holds MISO=1 after R1.
   - Response: `rd_err` with code 10 after 4095 clocks plus the gap.
4. Gating:
   - Stimulus: `rd_req` while `init_ok`=0, and a second `rd_req` during a transfer.
   - Response: both ignored; exactly one `rd_done`.
5. Reset mid-RX_DATA:
   - Stimulus: assert `rst_n` low at byte 100.
   - Response: outputs go to reset values immediately; a new read then completes normally.
6. CRC (with `SD_RD_CRC16_EN`):
   - Stimulus: first a correct CRC, then one with 1 bit flipped.
   - Response: `rd_done` for the first read; `rd_err` with code 11 for the second.

Source files
------------

// File: rtl/sd_read_sector_pkg.sv
// Shared SD SPI definitions: command bytes, start token, error codes and
// the read-sector FSM state encoding.
package sd_read_sector_pkg;

    localparam logic [7:0] CMD0        = 8'h40;
    localparam logic [7:0] CMD8        = 8'h48;
    localparam logic [7:0] CMD17       = 8'h51;
    localparam logic [7:0] CMD55       = 8'h77;
    localparam logic [7:0] ACMD41      = 8'h69;
    localparam logic [7:0] CMD_TAIL    = 8'hFF;
    localparam logic [7:0] START_TOKEN = 8'hFE;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_R1    = 2'b01;
    localparam logic [1:0] ERR_TOKEN = 2'b10;
    localparam logic [1:0] ERR_CRC   = 2'b11;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam int          TMR_W      = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_CMD,
        ST_WAIT_R1,
        ST_R1_CAP,
        ST_WAIT_TOKEN,
        ST_RX_DATA,
        ST_RX_CRC,
        ST_GAP
    } rd_state_t;

    // 48-bit SPI command frame; CRC byte is a don't-care once CRC is off.
    function automatic logic [47:0] cmd_frame(input logic [7:0] cmd, input logic [31:0] arg);
        return {cmd, arg, CMD_TAIL};
    endfunction

endpackage

// File: rtl/sd_read_sector_crc16.sv
// sd_crc16: serial MSB-first CRC16-CCITT (init 0) with clear and enable.
// Only built when SD_RD_CRC16_EN is defined.
`ifdef SD_RD_CRC16_EN
module sd_crc16
    import sd_read_sector_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic fb;
    assign fb = crc[15] ^ din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            crc <= '0;
        else if (clr)
            crc <= '0;
        else if (en)
            crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end

endmodule
`endif

// File: rtl/sd_read_sector.sv
// sd_read_sector: CMD17 single-block reader on an SD card in SPI mode.
// Optional CRC16 check of the data block when SD_RD_CRC16_EN is defined.
//
// state         | meaning
// ST_IDLE       | waiting for rd_req with init_ok high
// ST_SEND_CMD   | CS low, shifting out the 48-bit CMD17 frame
// ST_WAIT_R1    | hunting for the R1 start bit, R1 timer running
// ST_R1_CAP     | capturing the remaining 7 bits of R1
// ST_WAIT_TOKEN | bitwise hunt for the 0xFE start token, token timer running
// ST_RX_DATA    | receiving 512 data bytes
// ST_RX_CRC     | receiving the 16-bit block CRC
// ST_GAP        | CS high for GAP_CLKS clocks, then done/err pulse
module sd_read_sector
    import sd_read_sector_pkg::*;
#(
    parameter int R1_TIMEOUT    = 255,
    parameter int TOKEN_TIMEOUT = 4095,
    parameter int GAP_CLKS      = 8
) (
    input  logic        SD_CK,
    input  logic        rst_n,
    input  logic        init_ok,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    input  logic        SD_MISO,
    output logic        SD_MOSI,
    output logic        SD_CSn,
    output logic        rd_busy,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        rd_done,
    output logic        rd_err,
    output logic [1:0]  rd_err_code
);

`ifdef SD_RD_CRC16_EN
    localparam int RX_W = 15;
`else
    localparam int RX_W = 7;
`endif

    rd_state_t        state;
    logic [47:0]      cmd_sr;
    logic [5:0]       bit_cnt;
    logic [9:0]       byte_cnt;
    logic [TMR_W-1:0] timer;
    logic [RX_W-1:0]  rx_sr;
    logic [7:0]       rx_byte;
    logic             tx_q;
    logic             cs_q;
    logic             crc_bad;

    assign rx_byte = {rx_sr[6:0], SD_MISO};

`ifdef SD_RD_CRC16_EN
    logic [15:0] crc_calc;

    sd_crc16 u_crc16 (
        .clk   (SD_CK),
        .rst_n (rst_n),
        .clr   (state == ST_IDLE),
        .en    (state == ST_RX_DATA),
        .din   (SD_MISO),
        .crc   (crc_calc)
    );

    assign crc_bad = (crc_calc != {rx_sr[14:0], SD_MISO});
`else
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge SD_CK or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cmd_sr      <= '1;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            timer       <= '0;
            rx_sr       <= '1;
            tx_q        <= 1'b1;
            cs_q        <= 1'b1;
            rd_busy     <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            rd_done     <= 1'b0;
            rd_err      <= 1'b0;
            rd_err_code <= ERR_NONE;
        end else begin
            rd_valid <= 1'b0;
            rd_done  <= 1'b0;
            rd_err   <= 1'b0;
            rx_sr    <= {rx_sr[RX_W-2:0], SD_MISO};
            // Losing init_ok mid-transfer still releases the card through the gap.
            if (rd_busy && !init_ok && state != ST_GAP) begin
                rd_err_code <= ERR_R1;
                tx_q        <= 1'b1;
                cs_q        <= 1'b1;
                timer       <= TMR_W'(GAP_CLKS);
                state       <= ST_GAP;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rd_req && init_ok) begin
                            cmd_sr      <= cmd_frame(CMD17, rd_addr);
                            bit_cnt     <= '0;
                            rd_busy     <= 1'b1;
                            rd_err_code <= ERR_NONE;
                            cs_q        <= 1'b0;
                            state       <= ST_SEND_CMD;
                        end
                    end
                    ST_SEND_CMD: begin
                        tx_q    <= cmd_sr[47];
                        cmd_sr  <= {cmd_sr[46:0], 1'b1};
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd47) begin
                            timer <= TMR_W'(R1_TIMEOUT);
                            state <= ST_WAIT_R1;
                        end
                    end
                    ST_WAIT_R1: begin
                        tx_q <= 1'b1;
                        if (!SD_MISO) begin
                            bit_cnt <= 6'd1;
                            state   <= ST_R1_CAP;
                        end else if (timer == '0) begin
                            rd_err_code <= ERR_R1;
                            cs_q        <= 1'b1;
                            timer       <= TMR_W'(GAP_CLKS);
                            state       <= ST_GAP;
                        end else begin
                            timer <= timer - TMR_W'(1);
                        end
                    end
                    ST_R1_CAP: begin
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd7) begin
                            if (rx_byte == 8'h00) begin
                                timer <= TMR_W'(TOKEN_TIMEOUT);
                                state <= ST_WAIT_TOKEN;
                            end else begin
                                rd_err_code <= ERR_R1;
                                cs_q        <= 1'b1;
                                timer       <= TMR_W'(GAP_CLKS);
                                state       <= ST_GAP;
                            end
                        end
                    end
                    ST_WAIT_TOKEN: begin
                        // Byte alignment for the data block restarts at the token's last bit.
                        if (rx_byte == START_TOKEN) begin
                            bit_cnt  <= '0;
                            byte_cnt <= '0;
                            state    <= ST_RX_DATA;
                        end else if (timer == '0) begin
                            rd_err_code <= ERR_TOKEN;
                            cs_q        <= 1'b1;
                            timer       <= TMR_W'(GAP_CLKS);
                            state       <= ST_GAP;
                        end else begin
                            timer <= timer - TMR_W'(1);
                        end
                    end
                    ST_RX_DATA: begin
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd7) begin
                            rd_data  <= rx_byte;
                            rd_valid <= 1'b1;
                            bit_cnt  <= '0;
                            if (byte_cnt == 10'd511)
                                state <= ST_RX_CRC;
                            else
                                byte_cnt <= byte_cnt + 10'd1;
                        end
                    end
                    ST_RX_CRC: begin
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd15) begin
                            if (crc_bad)
                                rd_err_code <= ERR_CRC;
                            cs_q  <= 1'b1;
                            timer <= TMR_W'(GAP_CLKS);
                            state <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        if (timer == '0) begin
                            rd_busy <= 1'b0;
                            rd_done <= (rd_err_code == ERR_NONE);
                            rd_err  <= (rd_err_code != ERR_NONE);
                            state   <= ST_IDLE;
                        end else begin
                            timer <= timer - TMR_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Card samples on the rising edge, so TX lines change on the falling edge.
    always_ff @(negedge SD_CK or negedge rst_n) begin
        if (!rst_n) begin
            SD_MOSI <= 1'b1;
            SD_CSn  <= 1'b1;
        end else begin
            SD_MOSI <= tx_q;
            SD_CSn  <= cs_q;
        end
    end

endmodule
